// File: rtl/rle_frame_writer_pkg.sv
// ----------------------------------------------------------------------------
// rle_frame_writer_pkg
//   Shared definitions for the 64x64, 4-bit palette-index framebuffer writer.
//   The framebuffer address type is also used by the VGA-side reader, which
//   reads the frame as frame[y][x] with x the fastest-moving index.
// ----------------------------------------------------------------------------
package rle_frame_writer_pkg;

   localparam int FB_XW     = 6;                  // log2 frame width
   localparam int FB_YW     = 6;                  // log2 frame height
   localparam int IDX_W     = 4;                  // palette index width
   localparam int RUN_W     = 4;                  // run field width (run = field+1)
   localparam int FB_AW     = FB_XW + FB_YW;      // framebuffer address width
   localparam int FB_PIXELS = 1 << FB_AW;         // 4096
   localparam int BYTE_W    = RUN_W + IDX_W;      // encoded stream byte width

   // Writer FSM encoding
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE      = 2'd0;
   localparam state_t ST_STREAM    = 2'd1;
   localparam state_t ST_SWAP_WAIT = 2'd2;

   // Framebuffer address, row-major: {y, x}
   typedef struct packed {
      logic [FB_YW-1:0] y;
      logic [FB_XW-1:0] x;
   } fb_addr_t;

   // One encoded stream byte: {run, index}
   typedef struct packed {
      logic [RUN_W-1:0] run;
      logic [IDX_W-1:0] idx;
   } rle_byte_t;

   // True for the bottom-right pixel of the frame
   function automatic logic is_last_pixel(input fb_addr_t a);
      return (a.y == {FB_YW{1'b1}}) && (a.x == {FB_XW{1'b1}});
   endfunction

endpackage

// File: rtl/rle_frame_writer_addr_counter.sv
// ----------------------------------------------------------------------------
// rle_frame_writer_addr_counter
//   Raster-order frame address counter (x fastest, then y).
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     clr        : synchronous clear to pixel 0 (wins over inc)
//     inc        : advance to the next pixel
//     cnt        : current pixel address {y, x}
//     last       : cnt is the final pixel of the frame
// ----------------------------------------------------------------------------
module rle_frame_writer_addr_counter
   import rle_frame_writer_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     clr,
   input  logic     inc,
   output fb_addr_t cnt,
   output logic     last
);

   logic [FB_AW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else if (clr)
         cnt_q <= '0;
      else if (inc)
         cnt_q <= cnt_q + 1'b1;
   end

   assign cnt  = fb_addr_t'(cnt_q);
   assign last = is_last_pixel(cnt);

endmodule

// File: rtl/rle_frame_writer.sv
// ----------------------------------------------------------------------------
// rle_frame_writer
//   Expands a run-length-encoded byte stream into one framebuffer write per
//   clock, in raster order, into the bank the display is not reading. After a
//   full frame the display bank is swapped during the next vertical blank.
//   Ports:
//     clk, rst_n  : pixel clock, asynchronous active-low reset
//     sof         : start-of-frame pulse from the stream source
//     in_valid    : in_data holds a byte
//     in_data     : {run[7:4], index[3:0]}, run length = run+1
//     in_ready    : byte accepted this cycle if in_valid
//     vblank      : display is outside the active area
//     wr_en       : framebuffer write strobe
//     wr_addr     : {y, x} write address
//     wr_data     : palette index written
//     wr_bank     : bank being written (never the displayed one)
//     disp_bank   : bank the VGA reader displays
//     frame_done  : pulse on the write of the last pixel
//     abort       : pulse when sof restarts a partial frame
// ----------------------------------------------------------------------------
module rle_frame_writer
   import rle_frame_writer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sof,
   input  logic              in_valid,
   input  logic [BYTE_W-1:0] in_data,
   output logic              in_ready,
   input  logic              vblank,
   output logic              wr_en,
   output logic [FB_AW-1:0]  wr_addr,
   output logic [IDX_W-1:0]  wr_data,
   output logic              wr_bank,
   output logic              disp_bank,
   output logic              frame_done,
   output logic              abort
);

   state_t           state;
   logic [RUN_W-1:0] remaining;   // pixels of the current run still to issue
   logic [IDX_W-1:0] cur_idx;     // index of the run being expanded
   rle_byte_t        in_byte;
   fb_addr_t         pix_cnt;     // address of the next write
   logic             pix_last;
   logic             accept;
   logic             issue;
   logic             cnt_clr;

   assign in_byte  = rle_byte_t'(in_data);

   // Only take a new byte once the previous run is fully issued.
   assign in_ready = (state == ST_STREAM) && (remaining == '0);
   assign accept   = in_valid && in_ready;

   // A write is issued this cycle (visible next cycle) either for the first
   // pixel of a freshly accepted byte or for a pending pixel of the current
   // run. A restarting sof suppresses both, which also drops a byte that
   // arrives in the same cycle.
   assign issue    = (state == ST_STREAM) && !sof && (accept || (remaining != '0));

   // sof restarts addressing from IDLE and STREAM; it is ignored while a
   // finished frame waits for vblank.
   assign cnt_clr  = sof && (state != ST_SWAP_WAIT);

   assign wr_bank  = ~disp_bank;

   rle_frame_writer_addr_counter u_addr_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (issue),
      .cnt   (pix_cnt),
      .last  (pix_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         remaining  <= '0;
         cur_idx    <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         disp_bank  <= 1'b0;
         frame_done <= 1'b0;
         abort      <= 1'b0;
      end else begin
         // Strobes are single-cycle unless re-asserted below.
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         abort      <= 1'b0;

         case (state)
            ST_IDLE: begin
               remaining <= '0;
               if (sof)
                  state <= ST_STREAM;
            end

            ST_STREAM: begin
               if (sof) begin
                  // Restart: drop any partial run, stay ready for a new frame.
                  remaining <= '0;
                  abort     <= 1'b1;
               end else if (issue) begin
                  wr_en   <= 1'b1;
                  wr_addr <= pix_cnt;
                  if (accept) begin
                     wr_data   <= in_byte.idx;
                     cur_idx   <= in_byte.idx;
                     remaining <= in_byte.run;
                  end else begin
                     wr_data   <= cur_idx;
                     remaining <= remaining - 1'b1;
                  end
                  // Last pixel of the frame: anything left of the run is
                  // discarded rather than wrapping to address 0.
                  if (pix_last) begin
                     frame_done <= 1'b1;
                     remaining  <= '0;
                     state      <= ST_SWAP_WAIT;
                  end
               end
            end

            ST_SWAP_WAIT: begin
               remaining <= '0;
               if (vblank) begin
                  disp_bank <= ~disp_bank;
                  state     <= ST_IDLE;
               end
            end

            default: begin
               state     <= ST_IDLE;
               remaining <= '0;
            end
         endcase
      end
   end

   // frame_done always coincides with the write of the last pixel.
   a_done_on_last: assert property (@(posedge clk) disable iff (!rst_n)
      frame_done |-> (wr_en && (wr_addr == {FB_AW{1'b1}})));

   // A restart cycle never carries a write.
   a_abort_no_write: assert property (@(posedge clk) disable iff (!rst_n)
      abort |-> !wr_en);

endmodule
